// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Brief    : Buffers ALU commands in a FIFO, issues them one at a time from a
//            register stage to a combinational ALU, and returns registered
//            responses over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Zero,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_op,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [2:0]            rsp_flags,
    output logic [15:0]           rsp_count
);

    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [2:0]            r_mem_op [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_a  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_b  [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [2:0]            r_alu_op;

    logic                  r_rsp_valid;
    logic [2:0]            r_rsp_op;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic [2:0]            r_rsp_flags;
    logic [15:0]           r_rsp_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rsp_free;
    logic w_rsp_fire;
    logic w_s1_adv;

    // Full/empty come from registered count only, so there is no bypass path.
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = cmd_valid & ~w_full;
    assign w_rsp_free = ~r_rsp_valid | rsp_ready;
    assign w_rsp_fire = r_rsp_valid & rsp_ready;
    assign w_s1_adv   = r_s1_valid & w_rsp_free;
    assign w_pop      = ~w_empty & (~r_s1_valid | w_s1_adv);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= cmd_op;
            r_mem_a[r_wr_ptr]  <= cmd_a;
            r_mem_b[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // S1 drives the ALU; it returns to all-zero operands when idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= 3'b000;
        end else if (w_pop) begin
            r_s1_valid <= 1'b1;
            r_alu_a    <= r_mem_a[r_rd_ptr];
            r_alu_b    <= r_mem_b[r_rd_ptr];
            r_alu_op   <= r_mem_op[r_rd_ptr];
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= 3'b000;
            r_rsp_result <= '0;
            r_rsp_flags  <= 3'b000;
            r_rsp_count  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_op     <= r_alu_op;
                r_rsp_result <= alu_Result;
                r_rsp_flags  <= {alu_Overflow, alu_CarryOut, alu_Zero};
            end else if (w_rsp_fire) begin
                r_rsp_valid  <= 1'b0;
            end
            if (w_rsp_fire) r_rsp_count <= r_rsp_count + 16'd1;
        end
    end

    assign cmd_ready  = ~w_full;
    assign alu_A      = r_alu_a;
    assign alu_B      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_op     = r_rsp_op;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_count  = r_rsp_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issuer
// Brief    : Self-checking bench with a behavioural ALU and in-order response
//            model for alu_cmd_issuer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'b000;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [31:0] alu_A, alu_B, alu_Result;
    logic [2:0]  alu_op;
    logic        alu_Zero, alu_Overflow, alu_CarryOut;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_op;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [15:0] rsp_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [37:0] exp_q[$];
    logic [15:0] model_count = '0;
    logic        hold_prev = 1'b0;
    logic [37:0] hold_data = '0;
    logic        seen_ffff = 1'b0;

    alu_cmd_issuer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_Result(alu_Result), .alu_Zero(alu_Zero),
        .alu_Overflow(alu_Overflow), .alu_CarryOut(alu_CarryOut),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    // Returns {Overflow, CarryOut, Zero, Result}; SUB reports borrow as CarryOut.
    function automatic logic [34:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic ov, co;
        ov = 1'b0; co = 1'b0; s = '0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: r = ~(a | b);
            3'b110: begin
                r  = a - b;
                co = a < b;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = {31'b0, $signed(a) < $signed(b)};
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    always_comb {alu_Overflow, alu_CarryOut, alu_Zero, alu_Result} = alu_f(alu_op, alu_A, alu_B);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: every accepted command yields exactly one response, in order.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            model_count = '0;
            hold_prev   = 1'b0;
        end else begin
            chk("rsp_count", rsp_count, model_count);
            if (rsp_count == 16'hFFFF) seen_ffff = 1'b1;
            if (hold_prev) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", {rsp_op, rsp_flags, rsp_result}, hold_data);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    chk("rsp_data", {rsp_op, rsp_flags, rsp_result}, exp_q.pop_front());
                end
                model_count = model_count + 16'd1;
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_data = {rsp_op, rsp_flags, rsp_result};
            if (cmd_valid && cmd_ready) exp_q.push_back({cmd_op, alu_f(cmd_op, cmd_a, cmd_b)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (n == 200) chk("send_timeout", 1, 0);
        else tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [2:0] op, input logic [31:0] res, input logic [2:0] fl);
        int n;
        n = 0;
        while (!(rsp_valid && rsp_ready) && n < 200) begin tick(); n++; end
        if (n == 200) begin
            chk({name, "_timeout"}, 1, 0);
        end else begin
            chk(name, {rsp_op, rsp_flags, rsp_result}, {op, fl, res});
            tick();
        end
    endtask

    initial begin
        apply_reset();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", {rsp_op, rsp_flags, rsp_result}, 0);
        chk("reset_alu", {alu_op, alu_A, alu_B}, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_count", rsp_count, 0);

        // ADD overflow and two-cycle latency
        rsp_ready = 1'b1;
        send(3'b010, 32'h7FFFFFFF, 32'h00000001);
        chk("lat_t0", rsp_valid, 0);
        tick();
        chk("lat_t1", rsp_valid, 0);
        tick();
        chk("lat_t2", rsp_valid, 1);
        chk("add_ovf", {rsp_op, rsp_flags, rsp_result}, {3'b010, 3'b100, 32'h80000000});
        tick();

        // Back-to-back SUB / SLT
        apply_reset();
        rsp_ready = 1'b1;
        send(3'b110, 32'd5, 32'd5);
        send(3'b111, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("sub_rsp", {rsp_valid, rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b110, 3'b001, 32'h0});
        tick();
        chk("slt_rsp", {rsp_valid, rsp_op, rsp_flags, rsp_result}, {1'b1, 3'b111, 3'b000, 32'h1});
        tick();
        chk("b2b_count", rsp_count, 2);
        chk("b2b_idle", rsp_valid, 0);

        // Capacity with the consumer stalled
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            chk("cap_ready", cmd_ready, 1);
            cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = i; cmd_b = i;
            tick();
        end
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 7; cmd_b = 7;
        chk("cap_full", cmd_ready, 0);
        tick();
        chk("cap_full_hold", cmd_ready, 0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 1; i <= 6; i++) expect_rsp("cap_rsp", 3'b010, 2 * i, 3'b000);
        send(3'b010, 32'd7, 32'd7);
        expect_rsp("cap_rsp7", 3'b010, 32'd14, 3'b000);

        // Alternating consumer readiness
        apply_reset();
        for (int i = 0; i < 4; i++) send(3'b100, 32'hA5A5_0000 + i, 32'h0F0F_F0F0);
        for (int i = 0; i < 20; i++) begin rsp_ready = ~rsp_ready; tick(); end
        chk("alt_count", rsp_count, 4);

        // Reset with commands in flight
        apply_reset();
        for (int i = 0; i < 5; i++) send(3'b001, i, 32'h100);
        chk("pre_rst_valid", rsp_valid, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_count", rsp_count, 0);
        rsp_ready = 1'b1;
        send(3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
        expect_rsp("and_after_rst", 3'b000, 32'hF000F000, 3'b000);
        repeat (4) tick();
        chk("no_stale_rsp", rsp_valid, 0);

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            cmd_valid = ($urandom % 4) != 0;
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = ($urandom % 4 == 0) ? 32'h7FFFFFFF : $urandom;
            cmd_b     = ($urandom % 4 == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom % 8 == 0) cmd_b = cmd_a;
            rsp_ready = ($urandom % 3) != 0;
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();
        chk("rand_drain", exp_q.size(), 0);

        // rsp_count wrap after 65536 responses
        apply_reset();
        rsp_ready = 1'b1;
        begin
            int sent, guard;
            sent = 0; guard = 0;
            while (sent < 65536 && guard < 70000) begin
                cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = sent; cmd_b = 32'd1;
                if (cmd_ready) sent++;
                tick();
                guard++;
            end
            chk("wrap_sent", sent, 65536);
        end
        cmd_valid = 1'b0;
        repeat (6) tick();
        chk("wrap_seen_ffff", seen_ffff, 1);
        chk("wrap_count", rsp_count, 16'h0000);
        chk("wrap_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the ALU operand/opcode interface. Accepts ALU commands (opcode, A, B) over a valid/ready stream and buffers them in a small FIFO. Drives them one at a time from a register stage onto a combinational ALU. Captures Result and flags into a response register presented over a second valid/ready stream. Sits between the datapath control/test harness and the ALU instance.

Parameters:
DATA_WIDTH, 32, operand/result width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept command
cmd_op  in  3  ALU opcode: AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111
cmd_a  in  DATA_WIDTH  operand A
cmd_b  in  DATA_WIDTH  operand B
alu_A  out  DATA_WIDTH  to ALU A
alu_B  out  DATA_WIDTH  to ALU B
alu_op  out  3  to ALU ALUop
alu_Result  in  DATA_WIDTH  from ALU (combinational from alu_A/B/op)
alu_Zero  in  1  from ALU
alu_Overflow  in  1  from ALU
alu_CarryOut  in  1  from ALU
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_op  out  3  opcode of the response
rsp_result  out  DATA_WIDTH  captured Result
rsp_flags  out  3  {Overflow, CarryOut, Zero} captured
rsp_count  out  16  number of responses consumed (rsp_valid&rsp_ready), wraps 0xFFFF->0

Behaviour:
- Reset (resetn=0 at edge): FIFO empty (pointers 0, count 0), S1 invalid, RSP invalid, rsp_count=0. All queued/in-flight commands discarded, no response emitted. cmd_ready=1 from the first cycle after reset. Outputs after reset: rsp_valid=0, rsp_result=0, rsp_op=000, rsp_flags=000, alu_A=alu_B=0, alu_op=000.
- Three stages: FIFO -> S1 (registered alu_A/alu_B/alu_op + s1_valid) -> RSP (registered rsp_*).
- Push: cmd_valid & cmd_ready at edge writes the command at the write pointer. cmd_ready = !full, with full meaning count==FIFO_DEPTH. No pass-through when full: push is refused even if a pop occurs the same cycle.
- rsp_fire = rsp_valid & rsp_ready. rsp_free = !rsp_valid | rsp_ready.
- s1_adv = s1_valid & rsp_free. At the edge, RSP loads {alu_op, alu_Result, alu_Overflow, alu_CarryOut, alu_Zero} and rsp_valid=1.
- If rsp_fire & !s1_adv, rsp_valid clears. rsp_* data holds its last value when not loading.
- pop = !empty & (!s1_valid | s1_adv). Empty is registered state, so a command pushed at edge t is poppable at edge t+1 at the earliest; no FIFO bypass. On pop, S1 loads the head entry and s1_valid=1.
- If s1_adv & !pop, s1_valid clears and alu_A/alu_B/alu_op return to 0/0/000 (idle value).
- Simultaneous push and pop: both occur; count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: command accepted at edge t -> S1 at t+1 -> rsp_valid high after edge t+2. Minimum 2 cycles, no bubbles at full throughput (1 command/cycle with rsp_ready=1).
- Capacity with rsp_ready=0: FIFO_DEPTH+2 commands are absorbed before cmd_ready drops.
- Strict in-order: responses match command order exactly.
- The issuer does not interpret opcodes or flags; flags are captured verbatim.
- rsp_count increments by 1 on each rsp_fire.

Test Plan:
- ADD cmd_a=0x7FFFFFFF, cmd_b=0x00000001, rsp_ready=1 -> rsp_valid 2 cycles after accept: rsp_result=0x80000000, rsp_flags=100, rsp_op=010.
- SUB 5,5 then SLT 0xFFFFFFFF,1 back-to-back -> rsp 0x00000000 flags=001, then rsp 0x00000001 flags=000 on consecutive cycles; rsp_count=2.
- rsp_ready=0, push 7 commands ADD i,i for i=1..7 -> first 6 accepted, cmd_ready=0 from the cycle after the 6th accept. Then rsp_ready=1 -> results 2,4,6,8,10,12 in order, 7th command then accepted and returns 14.
- Alternating rsp_ready (1,0,1,0...) with 4 queued XOR commands -> no loss or duplication; each rsp_result is held stable while rsp_valid=1 & rsp_ready=0.
- resetn=0 for one edge while FIFO holds 3 commands and RSP is valid -> next cycle rsp_valid=0, cmd_ready=1, rsp_count=0. A new AND 0xF0F0F0F0,0xFF00FF00 returns 0xF000F000.
- 65536 responses consumed -> rsp_count wraps to 0x0000.
